// File: rtl/nios_system_tick_scheduler.sv
// nios_system_tick_scheduler
// Software-timer scheduler hanging off the interval timer's periodic tick.
// Each accepted tick starts a scan that visits one virtual channel per clock,
// decrementing enabled counts and raising pending flags on expiry.
// Optional feature macro: NIOS_TICK_SCHED_PRESCALE_EN adds a tick prescaler
// register at word address 12.
module nios_system_tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             tick_q_reg, tick_q_next;
  logic             ovr_set;
  logic             busy;

  logic [NUM_CH-1:0] enable_reg, enable_next;
  logic [NUM_CH-1:0] irq_mask_reg;
  logic [NUM_CH-1:0] oneshot_reg;
  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic              overrun_reg, overrun_next;
  logic [CNT_W-1:0]  period_reg [NUM_CH];
  logic [CNT_W-1:0]  count_reg  [NUM_CH];
  logic [CNT_W-1:0]  count_next [NUM_CH];
  logic [NUM_CH-1:0] expire;

  logic [15:0] readdata_reg, readdata_next;

  logic wr, status_wr, control_wr, mask_wr, oneshot_wr;
  logic tick_in;

  assign wr         = chipselect && !write_n;
  assign status_wr  = wr && (address == 4'd0);
  assign control_wr = wr && (address == 4'd1);
  assign mask_wr    = wr && (address == 4'd2);
  assign oneshot_wr = wr && (address == 4'd3);
  assign busy       = (state_reg == ST_SCAN);

`ifdef NIOS_TICK_SCHED_PRESCALE_EN
  logic [7:0] prescale_reg;
  logic [7:0] div_reg;
  logic       prescale_wr;

  assign prescale_wr = wr && (address == 4'd12);
  // A tick passes once the divider has counted PRESCALE dropped ticks.
  assign tick_in     = tick && (div_reg >= prescale_reg);

  // Prescale register and tick divider; a PRESCALE write restarts the divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_reg <= '0;
      div_reg      <= '0;
    end else if (prescale_wr) begin
      prescale_reg <= writedata[7:0];
      div_reg      <= '0;
    end else if (tick) begin
      div_reg <= (div_reg >= prescale_reg) ? 8'd0 : div_reg + 8'd1;
    end
  end
`else
  assign tick_in = tick;
`endif

  // Scan sequencer: one channel per cycle, one-deep queue for ticks that
  // arrive mid-scan. A tick on the last scan cycle restarts the scan at
  // once so that channel c is always serviced 1+c cycles after its tick.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    tick_q_next = tick_q_reg;
    ovr_set     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick_in) begin
          state_next = ST_SCAN;
          idx_next   = '0;
        end
      end
      ST_SCAN: begin
        if (tick_in && tick_q_reg) begin
          ovr_set = 1'b1;
        end
        if (idx_reg == LAST_IDX) begin
          idx_next    = '0;
          tick_q_next = 1'b0;
          if (!(tick_q_reg || tick_in)) begin
            state_next = ST_IDLE;
          end
        end else begin
          idx_next = idx_reg + 1'b1;
          if (tick_in) begin
            tick_q_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      tick_q_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      tick_q_reg <= tick_q_next;
    end
  end

  // Per-channel step and CPU-override logic. CPU writes to CONTROL/PERIOD
  // take priority over the scan step; a hardware pending set beats a
  // software clear.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic step_hit;
      logic per_wr;
      logic reload_on_enable;

      assign step_hit         = busy && (idx_reg == IDX_W'(gi)) && enable_reg[gi];
      assign expire[gi]       = step_hit && ((count_reg[gi] >> 1) == '0);
      assign per_wr           = wr && (address == 4'(4 + gi));
      assign reload_on_enable = control_wr && writedata[gi] && !enable_reg[gi];

      assign count_next[gi] = per_wr           ? writedata[CNT_W-1:0] :
                              reload_on_enable ? period_reg[gi] :
                              expire[gi]       ? period_reg[gi] :
                              step_hit         ? count_reg[gi] - CNT_W'(1) :
                                                 count_reg[gi];

      assign enable_next[gi] = control_wr ? writedata[gi] :
                               (expire[gi] && oneshot_reg[gi]) ? 1'b0 :
                               enable_reg[gi];

      assign pending_next[gi] = expire[gi] |
                                (pending_reg[gi] & ~(status_wr & writedata[gi]));
    end
  endgenerate

  assign overrun_next = ovr_set | (overrun_reg & ~(status_wr & writedata[15]));

  // Register file and channel counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg   <= '0;
      irq_mask_reg <= '0;
      oneshot_reg  <= '0;
      pending_reg  <= '0;
      overrun_reg  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        period_reg[c] <= '0;
        count_reg[c]  <= '0;
      end
    end else begin
      enable_reg  <= enable_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      if (mask_wr) begin
        irq_mask_reg <= writedata[NUM_CH-1:0];
      end
      if (oneshot_wr) begin
        oneshot_reg <= writedata[NUM_CH-1:0];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        count_reg[c] <= count_next[c];
        if (wr && (address == 4'(4 + c))) begin
          period_reg[c] <= writedata[CNT_W-1:0];
        end
      end
    end
  end

  // Read mux; PERIOD addresses return the live count.
  always_comb begin
    readdata_next = '0;
    case (address)
      4'd0: begin
        readdata_next[NUM_CH-1:0] = pending_reg;
        readdata_next[14]         = busy;
        readdata_next[15]         = overrun_reg;
      end
      4'd1: readdata_next[NUM_CH-1:0] = enable_reg;
      4'd2: readdata_next[NUM_CH-1:0] = irq_mask_reg;
      4'd3: readdata_next[NUM_CH-1:0] = oneshot_reg;
`ifdef NIOS_TICK_SCHED_PRESCALE_EN
      4'd12: readdata_next[7:0] = prescale_reg;
`endif
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (address == 4'(4 + c)) begin
            readdata_next = 16'(count_reg[c]);
          end
        end
      end
    endcase
  end

  // Registered read data, one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else begin
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(pending_reg & irq_mask_reg);

endmodule
